// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared encodings for the multicycle shift unit: operation codes, amount
// source selects and the controller state type.
// -----------------------------------------------------------------------------
package shift_pkg;

   typedef enum logic [1:0] {
      OP_SLL = 2'b00,
      OP_SRL = 2'b01,
      OP_SRA = 2'b10,
      OP_ROR = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      SEL_SHAMT = 2'b00,   // instruction shamt field inside offset
      SEL_B     = 2'b01,   // low bits of register operand B
      SEL_CONST = 2'b10,   // build-time constant amount
      SEL_RSVD  = 2'b11    // reserved, behaves as amount 0
   } shamt_sel_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_e;

   // Width of the instruction immediate and position of its shamt field.
   localparam int unsigned OFFSET_W  = 16;
   localparam int unsigned SHAMT_LSB = 6;

endpackage

// File: rtl/shift_unit_if.sv
// -----------------------------------------------------------------------------
// shift_unit_if
// Request/result bundle between the control unit (master) and the shift unit
// (slave).
//   start     : request, only honoured while the unit is IDLE or DONE
//   op        : shift operation (op_e encoding)
//   shamt_sel : shift amount source (shamt_sel_e encoding)
//   offset    : instruction immediate carrying the shamt field
//   b         : register operand B
//   data_in   : value to shift
//   data_out  : working register / result
//   busy      : high while shifting
//   done      : one-cycle completion pulse
// -----------------------------------------------------------------------------
interface shift_unit_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [1:0]       shamt_sel;
   logic [15:0]      offset;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out;
   logic             busy;
   logic             done;

   modport master (
      output start, op, shamt_sel, offset, b, data_in,
      input  data_out, busy, done
   );

   modport slave (
      input  start, op, shamt_sel, offset, b, data_in,
      output data_out, busy, done
   );
endinterface

// File: rtl/shift_amount_sel.sv
// -----------------------------------------------------------------------------
// shift_amount_sel
// Combinational shift-amount multiplexer.
//   i_shamt_sel : amount source select
//   i_offset    : instruction immediate; field [SHAMT_LSB+SHAMT_W-1:SHAMT_LSB]
//   i_b         : low SHAMT_W bits of operand B
//   o_amount    : selected unsigned shift amount
// -----------------------------------------------------------------------------
module shift_amount_sel
   import shift_pkg::*;
#(
   parameter int unsigned SHAMT_W     = 5,
   parameter int unsigned CONST_SHAMT = 16
) (
   input  logic [1:0]          i_shamt_sel,
   input  logic [OFFSET_W-1:0] i_offset,
   input  logic [SHAMT_W-1:0]  i_b,
   output logic [SHAMT_W-1:0]  o_amount
);

   // Only the shamt field of the immediate matters; the rest is ignored.
   logic [OFFSET_W-1:0] w_unused_offset;
   assign w_unused_offset = i_offset;

   always_comb begin
      // NOTE: assign a default before the case so no path leaves o_amount
      // unassigned; otherwise synthesis infers a latch.
      o_amount = '0;
      case (shamt_sel_e'(i_shamt_sel))
         SEL_SHAMT: o_amount = i_offset[SHAMT_LSB +: SHAMT_W];
         SEL_B:     o_amount = i_b;
         SEL_CONST: o_amount = SHAMT_W'(CONST_SHAMT);
         default:   o_amount = '0;
      endcase
   end

endmodule

// File: rtl/shift_unit.sv
// -----------------------------------------------------------------------------
// shift_unit
// Multicycle SLL/SRL/SRA/ROR unit shifting up to STEP bits per clock.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : shift_unit_if slave (start/op/amount inputs, data_out/busy/done)
// The result stays on data_out until the next accepted start.
// -----------------------------------------------------------------------------
module shift_unit
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned SHAMT_W     = $clog2(WIDTH),
   parameter int unsigned STEP        = 1,
   parameter int unsigned CONST_SHAMT = 16
) (
   input  logic         clk,
   input  logic         reset,
   shift_unit_if.slave  bus
);

   // STEP may equal WIDTH, which needs one bit more than SHAMT_W.
   localparam logic [SHAMT_W:0] STEP_X = (SHAMT_W + 1)'(STEP);

   state_e               r_state;
   state_e               w_state_nxt;
   op_e                  r_op;
   logic [WIDTH-1:0]     r_data;
   logic [SHAMT_W-1:0]   r_rem;

   logic [SHAMT_W-1:0]   w_amount;
   logic [SHAMT_W-1:0]   w_k;
   logic [SHAMT_W-1:0]   w_rem_nxt;
   logic [2*WIDTH-1:0]   w_dbl;
   logic [WIDTH-1:0]     w_shifted;
   logic                 w_load;

   // Only the low SHAMT_W bits of B feed the amount select.
   logic [WIDTH-1:0]     w_unused_b;
   assign w_unused_b = bus.b;

   shift_amount_sel #(
      .SHAMT_W     (SHAMT_W),
      .CONST_SHAMT (CONST_SHAMT)
   ) u_amount_sel (
      .i_shamt_sel (bus.shamt_sel),
      .i_offset    (bus.offset),
      .i_b         (bus.b[SHAMT_W-1:0]),
      .o_amount    (w_amount)
   );

   // k = min(STEP, rem). The STEP branch is only taken when STEP <= rem,
   // so truncating STEP_X to SHAMT_W bits there is exact.
   assign w_k       = ({1'b0, r_rem} < STEP_X) ? r_rem : STEP_X[SHAMT_W-1:0];
   assign w_rem_nxt = r_rem - w_k;

   // Rotate right: the low half of the doubled word shifted right by k.
   assign w_dbl = {r_data, r_data} >> w_k;

   always_comb begin
      w_shifted = r_data;
      case (r_op)
         OP_SLL:  w_shifted = r_data << w_k;
         OP_SRL:  w_shifted = r_data >> w_k;
         OP_SRA:  w_shifted = $signed(r_data) >>> w_k;
         OP_ROR:  w_shifted = w_dbl[WIDTH-1:0];
         default: w_shifted = r_data;
      endcase
   end

   // Next-state logic. A start seen in DONE is accepted exactly as in IDLE.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            if (bus.start) begin
               w_load      = 1'b1;
               w_state_nxt = (w_amount != '0) ? SHIFT : DONE;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         SHIFT: begin
            if (w_rem_nxt == '0) begin
               w_state_nxt = DONE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values, independent of block order.
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_data <= '0;
         r_rem  <= '0;
         r_op   <= OP_SLL;
      end else if (w_load) begin
         r_data <= bus.data_in;
         r_rem  <= w_amount;
         r_op   <= op_e'(bus.op);
      end else if (r_state == SHIFT) begin
         r_data <= w_shifted;
         r_rem  <= w_rem_nxt;
      end
   end

   assign bus.data_out = r_data;
   assign bus.busy     = (r_state == SHIFT);
   assign bus.done     = (r_state == DONE);

endmodule

// File: tb/tb_shift_unit.sv
// -----------------------------------------------------------------------------
// tb_shift_unit
// Drives two shift units (STEP=1 and STEP=4) with identical requests and
// compares result, done timing, done pulse count and busy length against a
// behavioural model written from the shift rules.
// -----------------------------------------------------------------------------
module tb_shift_unit;
   import shift_pkg::*;

   localparam int W     = 32;
   localparam int CONST = 16;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   int n_checks = 0;
   int n_errors = 0;

   shift_unit_if #(.WIDTH(W)) bus1 ();
   shift_unit_if #(.WIDTH(W)) bus4 ();

   shift_unit #(.WIDTH(W), .STEP(1), .CONST_SHAMT(CONST)) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1.slave)
   );

   shift_unit #(.WIDTH(W), .STEP(4), .CONST_SHAMT(CONST)) u_dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus4.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int ref_amount(input logic [1:0] sel, input logic [15:0] off,
                                     input logic [31:0] b);
      case (sel)
         2'b00:   return (int'(off) / 64) % 32;
         2'b01:   return int'(b % 32);
         2'b10:   return CONST;
         default: return 0;
      endcase
   endfunction

   function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] x,
                                              input int n);
      case (op)
         2'b00:   return x << n;
         2'b01:   return x >> n;
         2'b10:   return x[31] ? ~((~x) >> n) : (x >> n);
         default: return (n == 0) ? x : ((x >> n) | (x << (32 - n)));
      endcase
   endfunction

   // Edge (start edge = 0) after which done is visible.
   function automatic int ref_lat(input int n, input int step);
      return (n == 0) ? 0 : (n + step - 1) / step;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic st, input logic [1:0] op, input logic [1:0] sel,
                        input logic [15:0] off, input logic [31:0] b, input logic [31:0] din);
      bus1.start = st; bus1.op = op; bus1.shamt_sel = sel;
      bus1.offset = off; bus1.b = b; bus1.data_in = din;
      bus4.start = st; bus4.op = op; bus4.shamt_sel = sel;
      bus4.offset = off; bus4.b = b; bus4.data_in = din;
   endtask

   task automatic set_start(input logic st, input logic [31:0] din);
      bus1.start = st; bus1.data_in = din;
      bus4.start = st; bus4.data_in = din;
   endtask

   // One request on both units; after acceptance the other inputs are
   // scrambled since they are don't-care. mid_start pulses start while both
   // units are still shifting (caller guarantees latency >= 2 on both).
   task automatic run_op(input string name, input logic [1:0] op, input logic [1:0] sel,
                         input logic [15:0] off, input logic [31:0] b,
                         input logic [31:0] din, input bit mid_start);
      int          n, l1, l4, exp_busy1, exp_busy4;
      int          first1, first4, dcnt1, dcnt4, bcnt1, bcnt4;
      logic [31:0] exp, r32;
      logic [15:0] r16;
      logic [1:0]  r2a, r2b;
      n         = ref_amount(sel, off, b);
      exp       = ref_result(op, din, n);
      l1        = ref_lat(n, 1);
      l4        = ref_lat(n, 4);
      exp_busy1 = l1;
      exp_busy4 = l4;
      first1 = -1; first4 = -1; dcnt1 = 0; dcnt4 = 0; bcnt1 = 0; bcnt4 = 0;
      drive(1'b1, op, sel, off, b, din);
      for (int e = 0; e <= l1 + 2; e++) begin
         @(posedge clk);
         #1;
         if (e == 0) begin
            r2a = 2'($urandom); r2b = 2'($urandom); r16 = 16'($urandom);
            r32 = $urandom;
            drive(1'b0, r2a, r2b, r16, r32, $urandom);
         end
         if (bus1.done) begin dcnt1++; if (first1 < 0) first1 = e; end
         if (bus4.done) begin dcnt4++; if (first4 < 0) first4 = e; end
         if (bus1.busy) bcnt1++;
         if (bus4.busy) bcnt4++;
         if (mid_start && e == 1) set_start(1'b1, $urandom);
         if (mid_start && e == 2) set_start(1'b0, $urandom);
      end
      check($sformatf("%s s1 data", name),  bus1.data_out, exp);
      check($sformatf("%s s4 data", name),  bus4.data_out, exp);
      check($sformatf("%s s1 done_edge", name), 32'(first1), 32'(l1));
      check($sformatf("%s s4 done_edge", name), 32'(first4), 32'(l4));
      check($sformatf("%s s1 done_cnt", name),  32'(dcnt1), 32'd1);
      check($sformatf("%s s4 done_cnt", name),  32'(dcnt4), 32'd1);
      check($sformatf("%s s1 busy_cyc", name),  32'(bcnt1), 32'(exp_busy1));
      check($sformatf("%s s4 busy_cyc", name),  32'(bcnt4), 32'(exp_busy4));
   endtask

   initial begin : main
      int dpulses;
      logic [1:0]  rop, rsel;
      logic [15:0] roff;
      logic [31:0] rb, rdin;

      drive(1'b0, 2'b00, 2'b00, 16'h0, 32'h0, 32'h0);

      // Reset state
      #2 reset = 1'b0;
      #1;
      check("rst s1 data", bus1.data_out, 32'h0);
      check("rst s4 data", bus4.data_out, 32'h0);
      check("rst s1 busy", 32'(bus1.busy), 32'h0);
      check("rst s1 done", 32'(bus1.done), 32'h0);
      check("rst s4 busy", 32'(bus4.busy), 32'h0);
      check("rst s4 done", 32'(bus4.done), 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;

      // Directed cases
      run_op("sll_shamt",  2'b00, 2'b00, 16'h0100, 32'h0,        32'h0000_0001, 1'b0);
      run_op("sra_b",      2'b10, 2'b01, 16'h0,    32'h0000_0023, 32'h8000_0000, 1'b0);
      run_op("sll_b5",     2'b00, 2'b01, 16'h0,    32'h0000_0005, 32'h0000_0001, 1'b0);
      run_op("ror_const",  2'b11, 2'b10, 16'h0,    32'h0,        32'h1234_5678, 1'b0);
      run_op("ror_rsvd",   2'b11, 2'b11, 16'hFFFF, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0);
      run_op("srl_zero",   2'b01, 2'b01, 16'h0,    32'h0000_0020, 32'hDEAD_BEEF, 1'b0);
      run_op("mid_start",  2'b11, 2'b10, 16'h0,    32'h0,        32'h1234_5678, 1'b1);

      // Back-to-back: start held during the DONE cycle
      dpulses = 0;
      drive(1'b1, 2'b00, 2'b01, 16'h0, 32'h1, 32'h0000_0005);
      @(posedge clk); #1;
      set_start(1'b0, 32'h0);
      @(posedge clk); #1;
      if (bus1.done) dpulses++;
      check("b2b first done", 32'({bus1.done, bus4.done}), 32'h3);
      check("b2b first data", bus1.data_out, 32'h0000_000A);
      drive(1'b1, 2'b00, 2'b01, 16'h0, 32'h1, 32'h0000_0003);
      @(posedge clk); #1;
      set_start(1'b0, 32'h0);
      if (bus1.done) dpulses++;
      check("b2b reload busy", 32'({bus1.busy, bus4.busy}), 32'h3);
      @(posedge clk); #1;
      if (bus1.done) dpulses++;
      check("b2b s1 data", bus1.data_out, 32'h0000_0006);
      check("b2b s4 data", bus4.data_out, 32'h0000_0006);
      @(posedge clk); #1;
      if (bus1.done) dpulses++;
      check("b2b done pulses", 32'(dpulses), 32'd2);

      // Reset in the middle of a shift
      drive(1'b1, 2'b11, 2'b10, 16'h0, 32'h0, 32'hCAFE_F00D);
      @(posedge clk); #1;
      set_start(1'b0, 32'h0);
      @(posedge clk);
      @(posedge clk); #1;
      check("mrst pre busy", 32'({bus1.busy, bus4.busy}), 32'h3);
      reset = 1'b0;
      #1;
      check("mrst s1 data", bus1.data_out, 32'h0);
      check("mrst s4 data", bus4.data_out, 32'h0);
      check("mrst busy", 32'({bus1.busy, bus4.busy}), 32'h0);
      check("mrst done", 32'({bus1.done, bus4.done}), 32'h0);
      dpulses = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (bus1.done || bus4.done) dpulses++;
      end
      check("mrst no done", 32'(dpulses), 32'd0);
      reset = 1'b1;
      run_op("post_rst", 2'b00, 2'b01, 16'h0, 32'h1, 32'h0000_0001, 1'b0);

      // Randomized requests
      for (int i = 0; i < 40; i++) begin
         rop  = 2'($urandom);
         rsel = 2'($urandom);
         roff = 16'($urandom);
         rb   = $urandom;
         rdin = $urandom;
         run_op($sformatf("rnd%0d", i), rop, rsel, roff, rb, rdin, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
